fxp_divider_seq: RTL
====================

Name: fxp_divider_seq

Overview:
- Parameterised sequential unsigned fixed-point divider; restoring algorithm, one quotient bit per clock.
- Operands and quotient use the same Q(WIDTH-FRAC).FRAC format.
- Generalises the fixed 10-bit divider: adds width/fraction parameters, a remainder output, back-to-back operation and optional round-to-nearest.
- Sits on the datapath as a start/busy/valid coprocessor.

Parameters:
WIDTH, 10, operand/quotient/remainder width in bits; WIDTH >= 2
FRAC, 5, fractional bits in a_in, b_in and q_out; 0 <= FRAC < WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
sclr  input  1  synchronous clear; forces IDLE, same output values as reset
start  input  1  request; sampled only in IDLE or DONE
a_in  input  WIDTH  dividend, unsigned Q(WIDTH-FRAC).FRAC
b_in  input  WIDTH  divisor, same format
q_out  output  WIDTH  quotient = floor(a*2^FRAC / b), saturated
r_out  output  WIDTH  remainder of a*2^FRAC mod b, raw integer units, pre-rounding
dvz  output  1  divide by zero on the last operation
ovf  output  1  quotient exceeded WIDTH bits; q_out saturated
busy  output  1  high while iterating
valid  output  1  one-cycle pulse: results and flags are updated

Behaviour:
- Reset (rst or sclr): state IDLE. q_out=0, r_out=0, dvz=0, ovf=0, busy=0, valid=0. rst takes effect immediately; sclr takes effect at the clock edge. Either one aborts a division in flight with no valid pulse.
- N = WIDTH+FRAC iterations. Numerator = {a_in, FRAC zeros}, N bits wide. Partial-remainder register is WIDTH+1 bits.
- States:
  - IDLE: busy=0. On start with b_in!=0, latch a_in and b_in, clear the iteration counter and go to CALC. On start with b_in==0, go to DONE with dvz=1, ovf=0, q_out=all ones, r_out=0.
  - CALC: busy=1 for exactly N cycles.
    - Each cycle: shift the next numerator bit (MSB first) into the remainder.
    - If remainder >= b: subtract b and shift quotient bit 1; else shift 0.
    - After the Nth iteration go to DONE.
  - DONE: lasts one cycle. valid=1, busy=0. Outputs are registered on entry.
    - ovf=1 if any of the top FRAC bits of the N-bit quotient is set; q_out is then all ones.
    - Otherwise q_out = low WIDTH bits of the quotient. r_out = final remainder.
    - start in DONE is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge k. busy is high in cycles k+1..k+N. valid is high in cycle k+N+1. Divide by zero: valid in cycle k+1, busy never asserted.
- q_out, r_out, dvz and ovf hold their values until the next DONE entry or a reset.
- start in CALC is ignored; a_in/b_in changes during CALC have no effect.
- ovf and dvz are mutually exclusive.

Optional Feature:
- Macro FXP_DIV_ROUND_EN.
- Defined: round to nearest, ties up. On DONE entry, if 2*remainder >= b, the quotient is incremented.
  - If the increment carries past WIDTH bits, set ovf and saturate q_out to all ones.
  - r_out still reports the unrounded remainder. Latency is unchanged.
- Undefined: truncation toward zero, as in Behaviour.

Test Plan (WIDTH=10, FRAC=5):
- Basic: a_in=10'b1000001000 (16.25), b_in=10'b0001110100 (3.625), 1-cycle start pulse -> busy for 15 cycles. Then a valid pulse with q_out=10'd143 (0010001111), r_out=52, dvz=0, ovf=0. Same result with FXP_DIV_ROUND_EN.
- Rounding: a_in=32 (1.0), b_in=96 (3.0) -> q_out=10, r_out=64 without the macro; q_out=11 with FXP_DIV_ROUND_EN.
- Divide by zero: a_in=32, b_in=0, start -> valid in the next cycle, dvz=1, q_out=10'h3FF, r_out=0, busy stays 0.
- Overflow: a_in=1023, b_in=1 -> after 15 busy cycles: ovf=1, q_out=10'h3FF, dvz=0.
- Back-to-back and ignored start:
  - Hold start high with the basic operands; in the DONE cycle switch to a_in=32, b_in=96.
  - Required: second busy starts the cycle after the first valid.
  - Required: start pulses during CALC do not restart the operation.
  - Required: second result q_out=10.
- Reset mid-operation:
  - Assert rst asynchronously at iteration 7 -> all outputs 0 immediately, no valid pulse.
  - Repeat with sclr -> same outputs at the next edge.
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/fxp_divider_seq.sv
// fxp_divider_seq
//   Sequential unsigned fixed-point divider (restoring, one quotient bit per
//   clock). Operands and quotient share the Q(WIDTH-FRAC).FRAC format; the
//   quotient is floor(a*2^FRAC / b), saturated to all ones on overflow.
//
//   Optional build macro: FXP_DIV_ROUND_EN
//     defined   -> quotient rounded to nearest, ties up (r_out stays unrounded)
//     undefined -> quotient truncated toward zero
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   sclr   synchronous clear, same effect as rst at the next edge
//   start  request, sampled only in IDLE or DONE
//   a_in   dividend   (WIDTH bits)
//   b_in   divisor    (WIDTH bits)
//   q_out  quotient   (WIDTH bits, saturated)
//   r_out  remainder of a*2^FRAC mod b, raw integer units
//   dvz    last operation divided by zero
//   ovf    last quotient did not fit WIDTH bits
//   busy   iterating
//   valid  one-cycle pulse when results/flags update
module fxp_divider_seq #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             dvz,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [N-1:0]     num_sr;   // numerator, consumed MSB first
    logic [N-1:0]     quo;
    logic [WIDTH:0]   rem;      // partial remainder, one guard bit
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_sh, rem_nx;
    logic             ge;
    logic [N-1:0]     quo_nx;
    logic [N:0]       q_fin;    // one extra bit catches the rounding carry
    logic             ovf_nx;

    always_comb begin
        // rem < b always holds, so the top bit shifted out is zero.
        rem_sh = (rem << 1) | {{WIDTH{1'b0}}, num_sr[N-1]};
        ge     = rem_sh >= {1'b0, b_reg};
        rem_nx = ge ? rem_sh - {1'b0, b_reg} : rem_sh;
        quo_nx = {quo[N-2:0], ge};
`ifdef FXP_DIV_ROUND_EN
        // Round half up: 2*r >= b means the dropped fraction is >= 0.5.
        q_fin  = {1'b0, quo_nx} +
                 {{N{1'b0}}, ({rem_nx[WIDTH-1:0], 1'b0} >= {1'b0, b_reg})};
`else
        q_fin  = {1'b0, quo_nx};
`endif
        // Anything at or above bit WIDTH does not fit the output format.
        ovf_nx = (q_fin >> WIDTH) != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            num_sr <= '0;
            quo    <= '0;
            rem    <= '0;
            b_reg  <= '0;
            cnt    <= '0;
            q_out  <= '0;
            r_out  <= '0;
            dvz    <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else if (sclr) begin
            state  <= IDLE;
            num_sr <= '0;
            quo    <= '0;
            rem    <= '0;
            b_reg  <= '0;
            cnt    <= '0;
            q_out  <= '0;
            r_out  <= '0;
            dvz    <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                // DONE accepts start exactly like IDLE for back-to-back use.
                IDLE, DONE: begin
                    if (start) begin
                        if (b_in != '0) begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            num_sr <= N'(a_in) << FRAC;
                            b_reg  <= b_in;
                            rem    <= '0;
                            quo    <= '0;
                            cnt    <= '0;
                        end else begin
                            state  <= DONE;
                            valid  <= 1'b1;
                            dvz    <= 1'b1;
                            ovf    <= 1'b0;
                            q_out  <= '1;
                            r_out  <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem    <= rem_nx;
                    quo    <= quo_nx;
                    num_sr <= num_sr << 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        dvz   <= 1'b0;
                        ovf   <= ovf_nx;
                        q_out <= ovf_nx ? '1 : q_fin[WIDTH-1:0];
                        r_out <= rem_nx[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
